// File: rtl/fifo_async_fwft.sv
// Dual-clock first-word-fall-through FIFO with Gray-coded pointer crossing,
// registered occupancy counts and almost-full/almost-empty flags.
// Optional write-side error reporting is built when FIFO_ASYNC_FWFT_ERR_EN is defined.
module fifo_async_fwft #(
    parameter int Nb          = 8,
    parameter int M           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          in_clk,
    input  logic          out_clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [Nb-1:0] in_data,
    input  logic [M:0]    in_afull_thresh,
    output logic [M:0]    in_count,
    output logic          in_afull,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [Nb-1:0] out_data,
    input  logic [M:0]    out_aempty_thresh,
    output logic [M:0]    out_count,
    output logic          out_aempty
`ifdef FIFO_ASYNC_FWFT_ERR_EN
    ,
    output logic          in_overflow,
    output logic [7:0]    in_drop_count
`endif
);
    localparam int N = 1 << M;

    function automatic logic [M:0] bin2gray(input logic [M:0] b);
        return b ^ {1'b0, b[M:1]};
    endfunction

    function automatic logic [M:0] gray2bin(input logic [M:0] g);
        logic [M:0] b;
        b[M] = g[M];
        for (int i = M - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [Nb-1:0] mem_q [N];

    // write-domain state
    logic [M:0] wr_bin_q, wr_bin_d;
    logic [M:0] wr_gray_q, wr_gray_d;
    logic [M:0] rd_gray_sync_q [SYNC_STAGES];
    logic [M:0] rd_gray_sync_d [SYNC_STAGES];
    logic       full_q, full_d;
    logic [M:0] in_count_q, in_count_d;
    logic       in_afull_q, in_afull_d;
    logic       wr_en_s;
    logic [M:0] rd_gray_s;

    // read-domain state
    logic [M:0]    rd_bin_q, rd_bin_d;
    logic [M:0]    rd_gray_q, rd_gray_d;
    logic [M:0]    wr_gray_sync_q [SYNC_STAGES];
    logic [M:0]    wr_gray_sync_d [SYNC_STAGES];
    logic          out_valid_q, out_valid_d;
    logic [Nb-1:0] out_data_q, out_data_d;
    logic [M:0]    out_count_q, out_count_d;
    logic          out_aempty_q, out_aempty_d;
    logic [M:0]    wr_gray_s;
    logic [M:0]    wr_bin_s;
    logic          mem_empty_s;
    logic          prefetch_s;

    // Write-domain next state: pointer advance, full detection, count and flag.
    always_comb begin
        wr_en_s   = in_valid && !full_q && !reset;
        rd_gray_s = rd_gray_sync_q[SYNC_STAGES-1];
        wr_bin_d   = wr_bin_q;
        wr_gray_d  = wr_gray_q;
        full_d     = full_q;
        in_count_d = in_count_q;
        in_afull_d = in_afull_q;
        if (reset) begin
            rd_gray_sync_d[0] = {(M+1){1'b0}};
        end else begin
            rd_gray_sync_d[0] = rd_gray_q;
        end
        for (int i = 1; i < SYNC_STAGES; i++) begin
            if (reset) begin
                rd_gray_sync_d[i] = {(M+1){1'b0}};
            end else begin
                rd_gray_sync_d[i] = rd_gray_sync_q[i-1];
            end
        end
        if (reset) begin
            wr_bin_d   = {(M+1){1'b0}};
            wr_gray_d  = {(M+1){1'b0}};
            full_d     = 1'b0;
            in_count_d = {(M+1){1'b0}};
            in_afull_d = (in_afull_thresh == {(M+1){1'b0}});
        end else begin
            wr_bin_d   = wr_bin_q + {{M{1'b0}}, wr_en_s};
            wr_gray_d  = bin2gray(wr_bin_d);
            // Full when the write pointer is one lap ahead of the synced read pointer.
            full_d     = (wr_gray_d == {~rd_gray_s[M:M-1], rd_gray_s[M-2:0]});
            in_count_d = wr_bin_d - gray2bin(rd_gray_s);
            in_afull_d = (in_count_d >= in_afull_thresh);
        end
    end

    // Write-domain registers.
    always_ff @(posedge in_clk) begin
        wr_bin_q       <= wr_bin_d;
        wr_gray_q      <= wr_gray_d;
        rd_gray_sync_q <= rd_gray_sync_d;
        full_q         <= full_d;
        in_count_q     <= in_count_d;
        in_afull_q     <= in_afull_d;
    end

    // Storage array, written only on accepted words.
    always_ff @(posedge in_clk) begin
        if (wr_en_s) begin
            mem_q[wr_bin_q[M-1:0]] <= in_data;
        end
    end

    // Read-domain next state: head-register prefetch, pointer advance, count and flag.
    always_comb begin
        wr_gray_s   = wr_gray_sync_q[SYNC_STAGES-1];
        wr_bin_s    = gray2bin(wr_gray_s);
        mem_empty_s = (rd_gray_q == wr_gray_s);
        prefetch_s  = !reset && !mem_empty_s && (!out_valid_q || out_ready);
        rd_bin_d     = rd_bin_q;
        rd_gray_d    = rd_gray_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        out_aempty_d = out_aempty_q;
        if (reset) begin
            wr_gray_sync_d[0] = {(M+1){1'b0}};
        end else begin
            wr_gray_sync_d[0] = wr_gray_q;
        end
        for (int i = 1; i < SYNC_STAGES; i++) begin
            if (reset) begin
                wr_gray_sync_d[i] = {(M+1){1'b0}};
            end else begin
                wr_gray_sync_d[i] = wr_gray_sync_q[i-1];
            end
        end
        if (reset) begin
            rd_bin_d     = {(M+1){1'b0}};
            rd_gray_d    = {(M+1){1'b0}};
            out_valid_d  = 1'b0;
            out_data_d   = {Nb{1'b0}};
            out_count_d  = {(M+1){1'b0}};
            out_aempty_d = 1'b1;
        end else begin
            rd_bin_d  = rd_bin_q + {{M{1'b0}}, prefetch_s};
            rd_gray_d = bin2gray(rd_bin_d);
            if (prefetch_s) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[rd_bin_q[M-1:0]];
            end else if (out_ready) begin
                out_valid_d = 1'b0;
                out_data_d  = out_data_q;
            end else begin
                out_valid_d = out_valid_q;
                out_data_d  = out_data_q;
            end
            // Head register counts as one available word.
            out_count_d  = wr_bin_s - rd_bin_d + {{M{1'b0}}, out_valid_d};
            out_aempty_d = (out_count_d <= out_aempty_thresh);
        end
    end

    // Read-domain registers.
    always_ff @(posedge out_clk) begin
        rd_bin_q       <= rd_bin_d;
        rd_gray_q      <= rd_gray_d;
        wr_gray_sync_q <= wr_gray_sync_d;
        out_valid_q    <= out_valid_d;
        out_data_q     <= out_data_d;
        out_count_q    <= out_count_d;
        out_aempty_q   <= out_aempty_d;
    end

`ifdef FIFO_ASYNC_FWFT_ERR_EN
    logic       in_overflow_q, in_overflow_d;
    logic [7:0] in_drop_count_q, in_drop_count_d;
    logic       reject_s;

    // Sticky overflow flag and saturating rejected-cycle counter.
    always_comb begin
        reject_s        = in_valid && full_q && !reset;
        in_overflow_d   = in_overflow_q;
        in_drop_count_d = in_drop_count_q;
        if (reset) begin
            in_overflow_d   = 1'b0;
            in_drop_count_d = 8'd0;
        end else if (reject_s) begin
            in_overflow_d = 1'b1;
            if (in_drop_count_q != 8'hFF) begin
                in_drop_count_d = in_drop_count_q + 8'd1;
            end else begin
                in_drop_count_d = in_drop_count_q;
            end
        end else begin
            in_overflow_d   = in_overflow_q;
            in_drop_count_d = in_drop_count_q;
        end
    end

    // Error-reporting registers.
    always_ff @(posedge in_clk) begin
        in_overflow_q   <= in_overflow_d;
        in_drop_count_q <= in_drop_count_d;
    end

    assign in_overflow   = in_overflow_q;
    assign in_drop_count = in_drop_count_q;
`endif

    assign in_ready   = !full_q && !reset;
    assign in_count   = in_count_q;
    assign in_afull   = in_afull_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_count  = out_count_q;
    assign out_aempty = out_aempty_q;

endmodule

// File: doc/fifo_async_fwft.md
Name: fifo_async_fwft

Overview:
Parametrised dual-clock FIFO with first-word-fall-through output, configurable synchroniser depth and run-time almost-full/almost-empty thresholds. Used between converter-slot clock domains and the host/DSP domain where the consumer needs head data without a read-request cycle and producers need early back-pressure. Gray-coded pointer crossing; occupancy flags are registered in their own domain.

Parameters:
Nb, 8, data width in bits
M, 4, log2 of memory depth; M >= 2
N, 1<<M, memory depth in words (derived; not overridden)
SYNC_STAGES, 2, flops per pointer synchroniser chain; legal 2..4

Ports:
in_clk  input  1  write-domain clock
out_clk  input  1  read-domain clock
reset  input  1  reset, synchronous, active-high; sampled by both clocks
in_valid  input  1  write request
in_ready  output  1  write accepted when in_valid && in_ready
in_data  input  Nb  write data
in_afull_thresh  input  M+1  almost-full level; quasi-static, write domain
in_count  output  M+1  memory occupancy seen from write domain
in_afull  output  1  in_count >= in_afull_thresh
out_valid  output  1  out_data holds head word
out_ready  input  1  pop when out_valid && out_ready
out_data  output  Nb  head word (registered)
out_aempty_thresh  input  M+1  almost-empty level; quasi-static, read domain
out_count  output  M+1  words available to reader, including the head register
out_aempty  output  1  out_count <= out_aempty_thresh

Behaviour:
- Pointers are M+1 bits: binary plus Gray copies, registered in their own domain. Only Gray values cross domains, each through SYNC_STAGES flops.
- Write domain:
  - full_next = (wr_gray_next == rd_gray_sync with top two bits inverted).
  - in_ready = !full_reg && !reset.
  - An accepted word is written to mem[wr_bin[M-1:0]] and wr_bin increments; pointers wrap modulo 2^(M+1).
- Read domain, with a one-word head register (out_data/out_valid):
  - Prefetch when mem is non-empty and (!out_valid || out_ready): out_data <= mem[rd_bin[M-1:0]], rd_bin++, out_valid <= 1.
  - Otherwise, if out_ready, out_valid <= 0.
  - Sustained 1 word/out_clk throughput while data is available.
- Total capacity is N+1 words: N in memory plus 1 in the head register.
- Latency: a word written on in_clk edge k becomes out_valid no later than SYNC_STAGES+2 out_clk edges after the first out_clk edge following k.
- Counts:
  - in_count = wr_bin_next - bin(rd_gray_sync), registered; memory only, range 0..N.
  - out_count = bin(wr_gray_sync) - rd_bin_next + out_valid_next, registered; range 0..N+1.
  - Both counts are conservative: in_count can be high and out_count low, never the reverse.
- Flags:
  - in_afull and out_aempty are registered from the *_next count versus threshold (same cycle as the counts).
  - A threshold of 0 makes in_afull constantly 1; a threshold of N+1 or more makes out_aempty constantly 1.
- Simultaneous write and read in their own domains are always legal.
- Write attempted while full: ignored, data unchanged, pointer held.
- Pop while !out_valid: ignored.
- Reset values:
  - Write domain: in_count=0, in_afull=(in_afull_thresh==0), full_reg=0, sync chains=0.
  - Read domain: out_valid=0, out_data=0, out_count=0, out_aempty=1, sync chains=0.
- Reset must be held for at least SYNC_STAGES+2 cycles of the slower clock.
- Reset mid-operation discards all contents. No partial word survives, and out_valid is low on the first cycle after reset.

Optional Feature:
Macro FIFO_ASYNC_FWFT_ERR_EN.
- When defined, adds two write-domain outputs:
  - in_overflow (1 bit): sticky; set when in_valid && !in_ready && !reset; cleared only by reset.
  - in_drop_count (8 bits): saturating count of such rejected cycles; holds at 255.
- When undefined, neither port exists and no error logic is built.

Test Plan:
- M=2, SYNC_STAGES=2, in_clk 10 ns, out_clk 27 ns, out_ready=0. Write 0x01..0x06 back-to-back -> 5 accepted; in_ready=0 after 4th memory write plus head fill; in_count=4; 6th word not stored.
- Same fill, then out_ready=1 -> out_data sequence exactly 0x01..0x05, 1 word per out_clk, then out_valid=0 and out_count=0.
- Single write 0xA5 into empty FIFO -> out_valid rises within SYNC_STAGES+2 out_clks with out_data=0xA5, before any out_ready.
- in_afull_thresh=3, out_aempty_thresh=1 -> in_afull rises on the registered cycle in_count reaches 3; out_aempty falls when out_count becomes 2.
- Continuous random valid/ready, 10 000 words, clocks swapped (out faster) -> data in order, no loss or duplication, pointers wrapped at least 600 times.
- Reset asserted for 5 slow cycles with 3 words stored -> out_valid=0, in_count=0, out_count=0, in_ready=1 after release. With the macro defined, a write while full sets in_overflow and in_drop_count increments by 1 per rejected cycle.
